// File: rtl/mc_cu.sv
// mc_cu: multi-cycle control unit for the accumulator CPU (fetch/decode/exec/mem/wb/halt).
// Optional MC_CU_ILLEGAL_TRAP_EN: undefined opcodes trap to HALT and raise sticky illegal_op.
module mc_cu #(
    parameter int OP_W     = 4,
    parameter int ALU_OP_W = 4,
    parameter int TO_W     = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     opcode,
    input  logic                acc_neg,
    input  logic                mem_ready,
    input  logic                run,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                acc_wr,
    output logic                acc_clr,
    output logic                dmem_rd,
    output logic                dmem_wr,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                halted,
    output logic                mem_err,
    output logic [CNT_W-1:0]    instr_cnt
`ifdef MC_CU_ILLEGAL_TRAP_EN
    ,
    output logic                illegal_op
`endif
);
    localparam logic [OP_W-1:0] CLA  = OP_W'(0);
    localparam logic [OP_W-1:0] LDA  = OP_W'(1);
    localparam logic [OP_W-1:0] ADD  = OP_W'(2);
    localparam logic [OP_W-1:0] COM  = OP_W'(3);
    localparam logic [OP_W-1:0] SHR  = OP_W'(4);
    localparam logic [OP_W-1:0] CSL  = OP_W'(5);
    localparam logic [OP_W-1:0] STA  = OP_W'(6);
    localparam logic [OP_W-1:0] BAN  = OP_W'(7);
    localparam logic [OP_W-1:0] JMP  = OP_W'(8);
    localparam logic [OP_W-1:0] STOP = OP_W'(9);
    localparam logic [TO_W-1:0] WAIT_LAST = {TO_W{1'b1}} - TO_W'(1);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t          state;
    logic [OP_W-1:0] op_q;
    logic [TO_W-1:0] wcnt;
    logic [CNT_W-1:0] cnt_nx;
    logic            mem_op, alu_un;

    assign mem_op = op_q == LDA || op_q == ADD || op_q == STA;
    assign alu_un = op_q == COM || op_q == SHR || op_q == CSL;
    assign cnt_nx = &instr_cnt ? instr_cnt : instr_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            op_q      <= '0;
            wcnt      <= '0;
            instr_cnt <= '0;
            mem_err   <= 1'b0;
`ifdef MC_CU_ILLEGAL_TRAP_EN
            illegal_op <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    op_q  <= opcode;
                    state <= DECODE;
                end
                DECODE: begin
                    wcnt  <= '0;
                    state <= mem_op ? MEM : EXEC;
                end
                EXEC: begin
                    if (op_q == STOP) state <= HALT;
`ifdef MC_CU_ILLEGAL_TRAP_EN
                    else if (op_q > STOP) begin
                        illegal_op <= 1'b1;
                        state      <= HALT;
                    end
`endif
                    else begin
                        state     <= FETCH;
                        instr_cnt <= cnt_nx;
                    end
                end
                MEM: begin
                    // completion beats a timeout landing on the same cycle
                    if (mem_ready) begin
                        state <= op_q == STA ? FETCH : WB;
                        if (op_q == STA) instr_cnt <= cnt_nx;
                    end else begin
                        wcnt <= wcnt + TO_W'(1);
                        if (wcnt == WAIT_LAST) begin
                            mem_err <= 1'b1;
                            state   <= HALT;
                        end
                    end
                end
                WB: begin
                    state     <= FETCH;
                    instr_cnt <= cnt_nx;
                end
                HALT: begin
                    if (run) begin
                        state   <= FETCH;
                        mem_err <= 1'b0;
`ifdef MC_CU_ILLEGAL_TRAP_EN
                        illegal_op <= 1'b0;
`endif
                        // STOP retires on resume; timeout and trap halts do not
                        if (op_q == STOP) instr_cnt <= cnt_nx;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // strobes are gated by rst so everything is quiet while reset is held
    assign ir_load = rst && state == FETCH;
    assign pc_inc  = rst && state == FETCH;
    assign pc_load = rst && state == EXEC && (op_q == JMP || (op_q == BAN && acc_neg));
    assign acc_clr = rst && state == EXEC && op_q == CLA;
    assign acc_wr  = rst && ((state == EXEC && (op_q == CLA || alu_un)) || state == WB);
    assign dmem_rd = rst && state == MEM && op_q != STA;
    assign dmem_wr = rst && state == MEM && op_q == STA;
    assign alu_op  = rst && state inside {DECODE, EXEC, MEM, WB} ? ALU_OP_W'(op_q) : '0;
    assign halted  = state == HALT;
endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: directed scoreboard bench for mc_cu (default build, illegal trap disabled).
module tb_mc_cu;
    logic        clk = 1'b0;
    logic        rst, acc_neg, mem_ready, run;
    logic [3:0]  opcode, alu_op;
    logic        ir_load, pc_inc, pc_load, acc_wr, acc_clr, dmem_rd, dmem_wr, halted, mem_err;
    logic [15:0] instr_cnt;

    typedef struct {
        string       tag;
        logic [8:0]  s;
        logic [3:0]  a;
        logic [15:0] c;
    } exp_t;
    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;

    localparam logic [8:0] NONE = 9'b000000000;
    localparam logic [8:0] IRP  = 9'b110000000;
    localparam logic [8:0] PCL  = 9'b001000000;
    localparam logic [8:0] AW   = 9'b000100000;
    localparam logic [8:0] AC   = 9'b000010000;
    localparam logic [8:0] RD   = 9'b000001000;
    localparam logic [8:0] WR   = 9'b000000100;
    localparam logic [8:0] HL   = 9'b000000010;
    localparam logic [8:0] ME   = 9'b000000001;

    mc_cu dut (
        .clk(clk), .rst(rst), .opcode(opcode), .acc_neg(acc_neg), .mem_ready(mem_ready), .run(run),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .acc_wr(acc_wr), .acc_clr(acc_clr),
        .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .alu_op(alu_op), .halted(halted), .mem_err(mem_err),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // Inputs are already driven for the current state; check mid-cycle, then move to next negedge.
    task automatic cyc(input string tag, input logic [8:0] s, input logic [3:0] a, input logic [15:0] c);
        exp_t e;
        logic [8:0] obs;
        q.push_back('{tag, s, a, c});
        #1;
        e = q.pop_front();
        obs = {ir_load, pc_inc, pc_load, acc_wr, acc_clr, dmem_rd, dmem_wr, halted, mem_err};
        n_chk++;
        assert (obs === e.s) else begin
            n_fail++;
            $error("FAIL %s strobes got %b exp %b", e.tag, obs, e.s);
        end
        n_chk++;
        assert (alu_op === e.a) else begin
            n_fail++;
            $error("FAIL %s alu_op got %0d exp %0d", e.tag, alu_op, e.a);
        end
        n_chk++;
        assert (instr_cnt === e.c) else begin
            n_fail++;
            $error("FAIL %s instr_cnt got %0d exp %0d", e.tag, instr_cnt, e.c);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; opcode = '0; acc_neg = 1'b0; mem_ready = 1'b0; run = 1'b0;
        @(negedge clk);
        cyc("reset", NONE, 4'd0, 16'd0);
        // COM: 3-cycle ALU op
        rst = 1'b1; opcode = 4'd3;
        cyc("com_f", IRP, 4'd0, 16'd0);
        cyc("com_d", NONE, 4'd3, 16'd0);
        cyc("com_e", AW, 4'd3, 16'd0);
        // LDA with two wait cycles
        opcode = 4'd1;
        cyc("lda_f", IRP, 4'd0, 16'd1);
        cyc("lda_d", NONE, 4'd1, 16'd1);
        cyc("lda_m0", RD, 4'd1, 16'd1);
        cyc("lda_m1", RD, 4'd1, 16'd1);
        mem_ready = 1'b1;
        cyc("lda_m2", RD, 4'd1, 16'd1);
        mem_ready = 1'b0;
        cyc("lda_wb", AW, 4'd1, 16'd1);
        // BAN taken then not taken
        opcode = 4'd7;
        cyc("ban1_f", IRP, 4'd0, 16'd2);
        cyc("ban1_d", NONE, 4'd7, 16'd2);
        acc_neg = 1'b1;
        cyc("ban1_e", PCL, 4'd7, 16'd2);
        acc_neg = 1'b0;
        cyc("ban0_f", IRP, 4'd0, 16'd3);
        cyc("ban0_d", NONE, 4'd7, 16'd3);
        cyc("ban0_e", NONE, 4'd7, 16'd3);
        // CLA, JMP, undefined opcode as NOP
        opcode = 4'd0;
        cyc("cla_f", IRP, 4'd0, 16'd4);
        cyc("cla_d", NONE, 4'd0, 16'd4);
        cyc("cla_e", AW | AC, 4'd0, 16'd4);
        opcode = 4'd8;
        cyc("jmp_f", IRP, 4'd0, 16'd5);
        cyc("jmp_d", NONE, 4'd8, 16'd5);
        cyc("jmp_e", PCL, 4'd8, 16'd5);
        opcode = 4'd12;
        cyc("und_f", IRP, 4'd0, 16'd6);
        cyc("und_d", NONE, 4'd12, 16'd6);
        cyc("und_e", NONE, 4'd12, 16'd6);
        // STA with no mem_ready: 15 wait cycles then timeout halt
        opcode = 4'd6;
        cyc("sto_f", IRP, 4'd0, 16'd7);
        cyc("sto_d", NONE, 4'd6, 16'd7);
        for (int i = 0; i < 15; i++) cyc("sto_m", WR, 4'd6, 16'd7);
        cyc("sto_halt", HL | ME, 4'd0, 16'd7);
        run = 1'b1;
        cyc("sto_run", HL | ME, 4'd0, 16'd7);
        run = 1'b0; opcode = 4'd9;
        cyc("sto_resume", IRP, 4'd0, 16'd7);
        // STOP: run ignored until HALT, resume counts STOP
        run = 1'b1;
        cyc("stop_d", NONE, 4'd9, 16'd7);
        cyc("stop_e", NONE, 4'd9, 16'd7);
        run = 1'b0;
        cyc("stop_h0", HL, 4'd0, 16'd7);
        cyc("stop_h1", HL, 4'd0, 16'd7);
        run = 1'b1;
        cyc("stop_h2", HL, 4'd0, 16'd7);
        run = 1'b0; opcode = 4'd6;
        cyc("stop_resume", IRP, 4'd0, 16'd8);
        // STA completing immediately
        cyc("sta_d", NONE, 4'd6, 16'd8);
        mem_ready = 1'b1;
        cyc("sta_m", WR, 4'd6, 16'd8);
        mem_ready = 1'b0;
        // STA completing on the last allowed wait cycle
        cyc("stl_f", IRP, 4'd0, 16'd9);
        cyc("stl_d", NONE, 4'd6, 16'd9);
        for (int i = 0; i < 14; i++) cyc("stl_m", WR, 4'd6, 16'd9);
        mem_ready = 1'b1;
        cyc("stl_last", WR, 4'd6, 16'd9);
        mem_ready = 1'b0; opcode = 4'd2;
        cyc("stl_done", IRP, 4'd0, 16'd10);
        // ADD interrupted by reset during MEM
        cyc("add_d", NONE, 4'd2, 16'd10);
        cyc("add_m", RD, 4'd2, 16'd10);
        rst = 1'b0;
        cyc("add_rst", NONE, 4'd0, 16'd0);
        rst = 1'b1;
        cyc("add_post", IRP, 4'd0, 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
